// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU sequencer.
package div_ctrl_pkg;

    localparam int DIV_WIDTH = 32;

    // Quotient reported for a divide by zero at the default width.
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = {DIV_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_n,
    output logic [WIDTH-1:0] quo_n
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The trial difference is one bit wider so its msb acts as the borrow flag.
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};

    always_comb begin
        rem_n = shifted[WIDTH-1:0];
        quo_n = {quo[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_n = trial[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: restoring divide with sign fix-up, stall and flush.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    div_state_t       state;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             is_signed;
    logic             sign_q;
    logic             sign_r;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Magnitudes wrap for the most negative value, which the unsigned core handles.
    assign a_mag   = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign b_mag   = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    assign quo_fix = (is_signed && sign_q) ? -quo : quo;
    assign rem_fix = (is_signed && sign_r) ? -rem : rem;

    assign stall = (state == PREP) || (state == CALC) || (state == FIX);

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem    (rem),
        .quo    (quo),
        .divisor(divisor),
        .rem_n  (rem_n),
        .quo_n  (quo_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            is_signed <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            rem       <= '0;
            quo       <= '0;
            divisor   <= '0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else if (flush) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        is_signed <= signed_div;
                        state     <= PREP;
                    end
                end
                PREP: begin
                    if (b_q == '0) begin
                        hi    <= a_q;
                        lo    <= {WIDTH{1'b1}};
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        rem     <= '0;
                        quo     <= a_mag;
                        divisor <= b_mag;
                        sign_q  <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                        sign_r  <= a_q[WIDTH-1];
                        counter <= '0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    rem     <= rem_n;
                    quo     <= quo_n;
                    counter <= counter + 1'b1;
                    if (counter == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                // Results land in hi/lo on entry to DONE so they are valid with the pulse.
                FIX: begin
                    hi    <= rem_fix;
                    lo    <= quo_fix;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
